// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with a valid/ready handshake.
// Stage 1 applies the zero/negate presets to x and y and holds them with the
// f/no bits. Stage 2 selects AND or ADD, applies the output negate and
// registers the result together with its zr/ng flags.
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [5:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic [15:0]      count_o
);

    // Zero then optionally invert an operand, as the Hack presets define.
    function automatic logic [WIDTH-1:0] preset(input logic [WIDTH-1:0] v,
                                                input logic z,
                                                input logic n);
        logic [WIDTH-1:0] t;
        if (z) begin
            t = {WIDTH{1'b0}};
        end else begin
            t = v;
        end
        if (n) begin
            t = ~t;
        end else begin
            t = t;
        end
        return t;
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic             f_q, f_d;
    logic             no_q, no_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic [15:0]      count_q, count_d;

    // Handshake terms
    logic             s2_can_take_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic             out_hs_s;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] res_s;

    // Handshake decisions; in_ready never looks at in_valid.
    always_comb begin
        s2_can_take_s = !s2_valid_q || out_ready_i;
        s1_adv_s      = s1_valid_q && s2_can_take_s;
        in_ready_o    = !s1_valid_q || s2_can_take_s;
        accept_s      = in_valid_i && in_ready_o;
        out_hs_s      = s2_valid_q && out_ready_i;
    end

    // Stage 2 function unit: AND or ADD (carry dropped), then output negate.
    always_comb begin
        if (f_q) begin
            r_s = xs_q + ys_q;
        end else begin
            r_s = xs_q & ys_q;
        end
        if (no_q) begin
            res_s = ~r_s;
        end else begin
            res_s = r_s;
        end
    end

    // Next-state for both stages and the handshake counter; stalls hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        f_d        = f_q;
        no_d       = no_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        zr_d       = zr_q;
        ng_d       = ng_q;
        count_d    = count_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            xs_d       = preset(x_i, ctrl_i[5], ctrl_i[4]);
            ys_d       = preset(y_i, ctrl_i[3], ctrl_i[2]);
            f_d        = ctrl_i[1];
            no_d       = ctrl_i[0];
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            out_d      = res_s;
            zr_d       = (res_s == {WIDTH{1'b0}});
            ng_d       = res_s[WIDTH-1];
        end else if (out_hs_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (out_hs_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline and counter registers with synchronous reset priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            xs_q       <= {WIDTH{1'b0}};
            ys_q       <= {WIDTH{1'b0}};
            f_q        <= 1'b0;
            no_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= {WIDTH{1'b0}};
            zr_q       <= 1'b1;
            ng_q       <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            f_q        <= f_d;
            no_q       <= no_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
            count_q    <= count_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_o       = out_q;
    assign zr_o        = zr_q;
    assign ng_o        = ng_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: directed cases plus randomized
// traffic scored against a queue-based reference model of the ALU.
module tb_hack_alu_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] x_i;
    logic [15:0] y_i;
    logic [5:0]  ctrl_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_o;
    logic        zr_o;
    logic        ng_o;
    logic [15:0] count_o;

    hack_alu_pipe #(.WIDTH(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .x_i        (x_i),
        .y_i        (y_i),
        .ctrl_i     (ctrl_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_o      (out_o),
        .zr_o       (zr_o),
        .ng_o       (ng_o),
        .count_o    (count_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    int          cnt_m    = 0;
    logic [17:0] exp_q[$];

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the Hack rules using plain integer arithmetic.
    // Returns {ng, zr, out}.
    function automatic logic [17:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        int xs, ys, r, o;
        logic [15:0] ov;
        xs = c[5] ? 0 : int'(x);
        if (c[4]) xs = 65535 - xs;
        ys = c[3] ? 0 : int'(y);
        if (c[2]) ys = 65535 - ys;
        r  = c[1] ? (xs + ys) % 65536 : (xs & ys);
        o  = c[0] ? 65535 - r : r;
        ov = 16'(o);
        return {(o >= 32768), (o == 0), ov};
    endfunction

    // One clock cycle: drive at negedge, score handshakes, advance.
    task automatic step(input logic rst, input logic v, input logic [15:0] x,
                        input logic [15:0] y, input logic [5:0] c, input logic rdy);
        logic [17:0] e;
        rst_i = rst; in_valid_i = v; x_i = x; y_i = y; ctrl_i = c; out_ready_i = rdy;
        #1;
        if (rst) begin
            exp_q.delete();
            cnt_m = 0;
        end else begin
            check_eq("count", {16'd0, count_o}, cnt_m & 32'hFFFF);
            check_eq("spurious_valid", {31'd0, out_valid_o && (exp_q.size() == 0)}, 32'd0);
            if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("out", {16'd0, out_o}, {16'd0, e[15:0]});
                check_eq("zr", {31'd0, zr_o}, {31'd0, e[16]});
                check_eq("ng", {31'd0, ng_o}, {31'd0, e[17]});
                cnt_m++;
                n_out++;
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(alu_ref(x, y, c));
                n_acc++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Drain with out_ready high until the model queue empties (bounded).
    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("drained", exp_q.size(), 32'd0);
        check_eq("idle_valid", {31'd0, out_valid_o}, 32'd0);
    endtask

    logic [15:0] bx[5];
    logic [5:0]  codes[6];
    int          acc0, out0, idx;
    logic [5:0]  c;

    initial begin
        codes[0] = 6'b101010; codes[1] = 6'b111010; codes[2] = 6'b000000;
        codes[3] = 6'b000010; codes[4] = 6'b010011; codes[5] = 6'b001101;
        rst_i = 1'b1; in_valid_i = 1'b0; x_i = 16'h0; y_i = 16'h0;
        ctrl_i = 6'b0; out_ready_i = 1'b1;
        @(negedge clk_i);

        // Reset held 2 cycles with in_valid high
        step(1'b1, 1'b1, 16'h1111, 16'h2222, 6'b000010, 1'b1);
        step(1'b1, 1'b1, 16'h1111, 16'h2222, 6'b000010, 1'b1);
        rst_i = 1'b0; in_valid_i = 1'b0; #1;
        check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_out", {16'd0, out_o}, 32'h0);
        check_eq("rst_zr", {31'd0, zr_o}, 32'd1);
        check_eq("rst_ng", {31'd0, ng_o}, 32'd0);
        check_eq("rst_count", {16'd0, count_o}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);

        // Back-to-back with exact latency and constant expectations
        step(1'b0, 1'b1, 16'h00F0, 16'h0F0F, 6'b000000, 1'b1);
        check_eq("lat_not_yet", {31'd0, out_valid_o}, 32'd0);
        step(1'b0, 1'b1, 16'h0005, 16'h0003, 6'b000010, 1'b1);
        check_eq("b2b0_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("b2b0_out", {16'd0, out_o}, 32'h0000);
        check_eq("b2b0_zr", {31'd0, zr_o}, 32'd1);
        step(1'b0, 1'b1, 16'h0003, 16'h0005, 6'b010011, 1'b1);
        check_eq("b2b1_out", {16'd0, out_o}, 32'h0008);
        step(1'b0, 1'b1, 16'h1234, 16'hBEEF, 6'b101010, 1'b1);
        check_eq("b2b2_out", {16'd0, out_o}, 32'hFFFE);
        check_eq("b2b2_ng", {31'd0, ng_o}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("b2b3_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("b2b3_out", {16'd0, out_o}, 32'h0000);
        check_eq("b2b3_zr", {31'd0, zr_o}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("b2b_count", {16'd0, count_o}, 32'd4);
        check_eq("b2b_idle", {31'd0, out_valid_o}, 32'd0);

        // Adder wrap and flags
        step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 6'b000010, 1'b1);
        step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 6'b000010, 1'b1);
        check_eq("wrap0_out", {16'd0, out_o}, 32'h0000);
        check_eq("wrap0_zr", {31'd0, zr_o}, 32'd1);
        check_eq("wrap0_ng", {31'd0, ng_o}, 32'd0);
        step(1'b0, 1'b1, 16'h00FF, 16'h5A5A, 6'b001101, 1'b1);
        check_eq("wrap1_out", {16'd0, out_o}, 32'h8000);
        check_eq("wrap1_ng", {31'd0, ng_o}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("notx_out", {16'd0, out_o}, 32'hFF00);
        drain();

        // Backpressure: 5 beats offered while downstream is stalled
        for (int i = 0; i < 5; i++) bx[i] = 16'(16'h0100 * (i + 1) + i);
        acc0 = n_acc; out0 = n_out; idx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, bx[idx], 16'h0011, 6'b000010, 1'b0);
            if (n_acc - acc0 > idx) idx++;
        end
        check_eq("bp_accepted", idx, 32'd2);
        check_eq("bp_ready", {31'd0, in_ready_o}, 32'd0);
        check_eq("bp_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("bp_held", {16'd0, out_o}, 32'(bx[0] + 16'h0011));
        for (int k = 0; k < 20 && idx < 5; k++) begin
            step(1'b0, 1'b1, bx[idx], 16'h0011, 6'b000010, 1'b1);
            if (n_acc - acc0 > idx) idx++;
        end
        drain();
        check_eq("bp_total", n_out - out0, 32'd5);

        // Reset with two beats in flight
        step(1'b0, 1'b1, 16'h0101, 16'h0202, 6'b000010, 1'b0);
        step(1'b0, 1'b1, 16'h0303, 16'h0404, 6'b000010, 1'b0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("mid_rst_count", {16'd0, count_o}, 32'd0);
        step(1'b0, 1'b1, 16'h0002, 16'h0002, 6'b000010, 1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        check_eq("post_rst_out", {16'd0, out_o}, 32'h0004);
        drain();
        check_eq("post_rst_count", {16'd0, count_o}, 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            c = ($urandom_range(0, 3) == 0) ? 6'($urandom) : codes[$urandom_range(0, 5)];
            step(1'b0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), c,
                 ($urandom_range(0, 2) != 0));
        end
        drain();

        // Counter wrap: 65537 handshakes of constant -1
        step(1'b1, 1'b0, 16'h0, 16'h0, 6'b0, 1'b1);
        acc0 = n_acc;
        for (int k = 0; k < 70000 && (n_acc - acc0) < 65537; k++)
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 6'b111010, 1'b1);
        drain();
        check_eq("wrap_accepts", n_acc - acc0, 32'd65537);
        check_eq("wrap_count", {16'd0, count_o}, 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
